// File: rtl/uart_rx_fifo_if.sv
// FIFO read and error-status bundle of the UART receiver.
// The slave modport faces the receiver; the master modport faces the consumer.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                 rd_en;
   logic                 err_clr;
   logic [DATA_BITS-1:0] rd_data;
   logic                 empty;
   logic                 full;
   logic [CW-1:0]        count;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output rd_en, err_clr,
      input  rd_data, empty, full, count, frame_err, parity_err, overrun
   );

   modport slave (
      input  rd_en, err_clr,
      output rd_data, empty, full, count, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable frame format, feeding a
// first-word-fall-through FIFO and reporting sticky framing/parity/overrun errors.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   uart_rx_fifo_if.slave   bus
);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int TW       = $clog2(CLKS_PER_BIT);
   localparam int IW       = $clog2(DATA_BITS + 1);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_prev;
   logic [TW-1:0]        timer;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;
   logic                 push_pend;
   logic [DATA_BITS-1:0] push_word;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        cnt;

   logic                 frame_err_q;
   logic                 parity_err_q;
   logic                 overrun_q;

   logic                 half_tick;
   logic                 bit_tick;
   logic                 frame_evt;
   logic                 parity_evt;
   logic                 overrun_evt;
   logic                 is_full;
   logic                 is_empty;
   logic                 do_pop;
   logic                 do_push;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      half_tick   = 1'b0;
      bit_tick    = 1'b0;
      frame_evt   = 1'b0;
      parity_evt  = 1'b0;
      half_tick   = (timer == TW'(HALF_BIT - 1));
      bit_tick    = (timer == TW'(CLKS_PER_BIT - 1));
      if (state == S_STOP && bit_tick) begin
         frame_evt  = !rx_sync;
         parity_evt = rx_sync && par_bad && (bit_idx == IW'(STOP_BITS - 1));
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of the others regardless of order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= S_IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bad   <= 1'b0;
         push_pend <= 1'b0;
         push_word <= '0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         push_pend <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state <= S_START;
                  timer <= '0;
               end
            end

            // Mid-start sample; a high line here was only a glitch.
            S_START: begin
               if (half_tick) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  par_bad <= 1'b0;
                  state   <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_tick) begin
                  timer <= '0;
                  shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                  if (bit_idx == IW'(DATA_BITS - 1)) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // Odd parity wants the XOR over data and parity bit to be 1.
            S_PARITY: begin
               if (bit_tick) begin
                  timer   <= '0;
                  par_bad <= ((^shreg) ^ rx_sync) != (PARITY == 1);
                  state   <= S_STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_tick) begin
                  timer <= '0;
                  if (!rx_sync) begin
                     state <= S_BREAK;
                  end else if (bit_idx == IW'(STOP_BITS - 1)) begin
                     state     <= S_IDLE;
                     push_pend <= !par_bad;
                     push_word <= shreg;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_BREAK: begin
               if (rx_sync) begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      is_empty    = (cnt == '0);
      is_full     = (cnt == CW'(FIFO_DEPTH));
      do_pop      = bus.rd_en && !is_empty;
      do_push     = push_pend && (!is_full || do_pop);
      overrun_evt = push_pend && !do_push;
   end

   // NOTE: the storage array is deliberately not reset; pointers and count
   // define which entries are valid, and rd_data is forced to 0 while empty.
   always_ff @(posedge clk) begin
      if (rst && do_push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase

         // An event coinciding with err_clr wins, so the flag stays set.
         frame_err_q  <= (frame_err_q  && !bus.err_clr) || frame_evt;
         parity_err_q <= (parity_err_q && !bus.err_clr) || parity_evt;
         overrun_q    <= (overrun_q    && !bus.err_clr) || overrun_evt;
      end
   end

   assign bus.rd_data    = is_empty ? '0 : mem[rd_ptr];
   assign bus.empty      = is_empty;
   assign bus.full       = is_full;
   assign bus.count      = cnt;
   assign bus.frame_err  = frame_err_q;
   assign bus.parity_err = parity_err_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three receiver configurations share one
// clock; popped words are matched against expected-word queues by monitors.
module tb_uart_rx_fifo;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic rx_c = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   logic [8:0] q_c[$];

   always #5 clk = ~clk;

   // a: 8N1, b: 8E1, c: 7N2 -- all with a 4-deep FIFO.
   uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
   uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
   uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_c ();

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_a (.clk(clk), .rst(rst), .rx(rx_a), .bus(if_a));
   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_b (.clk(clk), .rst(rst), .rx(rx_b), .bus(if_b));
   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      u_c (.clk(clk), .rst(rst), .rx(rx_c), .bus(if_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: every accepted pop must match the oldest expected word.
   always @(negedge clk) begin
      if (rst && if_a.rd_en && !if_a.empty) begin
         if (q_a.size() == 0) check("a_unexpected_pop", 32'(if_a.rd_data), 32'h1ff);
         else check("a_pop_data", 32'(if_a.rd_data), 32'(q_a.pop_front()));
      end
      if (rst && if_b.rd_en && !if_b.empty) begin
         if (q_b.size() == 0) check("b_unexpected_pop", 32'(if_b.rd_data), 32'h1ff);
         else check("b_pop_data", 32'(if_b.rd_data), 32'(q_b.pop_front()));
      end
      if (rst && if_c.rd_en && !if_c.empty) begin
         if (q_c.size() == 0) check("c_unexpected_pop", 32'(if_c.rd_data), 32'h1ff);
         else check("c_pop_data", 32'(if_c.rd_data), 32'(q_c.pop_front()));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_rx(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // par_bit < 0 means no parity bit; rst_pos >= 0 pulses reset mid-way
   // through that bit position (0 = start bit) and abandons the frame.
   task automatic send_word(input int sel, input logic [8:0] data, input int dbits,
                            input int par_bit, input int nstop, input logic stop_lvl,
                            input int rst_pos);
      logic bits [16];
      int   n;
      n = 0;
      bits[n++] = 1'b0;
      for (int i = 0; i < dbits; i++) bits[n++] = data[i];
      if (par_bit >= 0) bits[n++] = par_bit[0];
      for (int i = 0; i < nstop; i++) bits[n++] = (i == 0) ? stop_lvl : 1'b1;
      for (int p = 0; p < n; p++) begin
         set_rx(sel, bits[p]);
         for (int c = 0; c < CPB; c++) begin
            if (p == rst_pos && c == CPB / 2) begin
               rst = 1'b0;
               tick(1);
               rst = 1'b1;
               set_rx(sel, 1'b1);
               return;
            end
            tick(1);
         end
      end
      set_rx(sel, 1'b1);
   endtask

   task automatic read_a();
      if_a.rd_en = 1'b1;
      tick(1);
      if_a.rd_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.rd_en = 1'b0; if_a.err_clr = 1'b0;
      if_b.rd_en = 1'b0; if_b.err_clr = 1'b0;
      if_c.rd_en = 1'b0; if_c.err_clr = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(2);

      @(negedge clk);
      check("rst_empty",   32'(if_a.empty),     32'd1);
      check("rst_full",    32'(if_a.full),      32'd0);
      check("rst_count",   32'(if_a.count),     32'd0);
      check("rst_rd_data", 32'(if_a.rd_data),   32'd0);
      check("rst_flags",   32'({if_a.frame_err, if_a.parity_err, if_a.overrun}), 32'd0);
      tick(1);

      // Two back-to-back 8N1 frames.
      send_word(0, 9'h55, 8, -1, 1, 1'b1, -1); q_a.push_back(9'h55);
      send_word(0, 9'hA3, 8, -1, 1, 1'b1, -1); q_a.push_back(9'hA3);
      tick(2);
      @(negedge clk);
      check("t1_count",   32'(if_a.count),   32'd2);
      check("t1_head",    32'(if_a.rd_data), 32'h55);
      tick(1);
      read_a();
      @(negedge clk);
      check("t1_head2",   32'(if_a.rd_data), 32'hA3);
      check("t1_flags",   32'({if_a.frame_err, if_a.parity_err, if_a.overrun}), 32'd0);
      tick(1);
      read_a();

      // Low stop bit, two idle bits, then a good frame.
      send_word(0, 9'h55, 8, -1, 1, 1'b0, -1);
      tick(2 * CPB);
      send_word(0, 9'h0F, 8, -1, 1, 1'b1, -1); q_a.push_back(9'h0F);
      tick(2);
      @(negedge clk);
      check("t2_frame_err", 32'(if_a.frame_err), 32'd1);
      check("t2_count",     32'(if_a.count),     32'd1);
      check("t2_head",      32'(if_a.rd_data),   32'h0F);
      tick(1);
      read_a();

      // Even parity: wrong then right parity bit for 0x07.
      send_word(1, 9'h07, 8, 0, 1, 1'b1, -1);
      tick(2);
      @(negedge clk);
      check("t3_parity_err", 32'(if_b.parity_err), 32'd1);
      check("t3_count0",     32'(if_b.count),      32'd0);
      tick(1);
      send_word(1, 9'h07, 8, 1, 1, 1'b1, -1); q_b.push_back(9'h07);
      tick(2);
      @(negedge clk);
      check("t3_count1", 32'(if_b.count),   32'd1);
      check("t3_head",   32'(if_b.rd_data), 32'h07);
      tick(1);
      if_b.rd_en = 1'b1; tick(1); if_b.rd_en = 1'b0;

      // Clear the earlier frame error, then fill the FIFO and overrun it.
      if_a.err_clr = 1'b1; tick(1); if_a.err_clr = 1'b0;
      @(negedge clk);
      check("t4_frame_clr", 32'(if_a.frame_err), 32'd0);
      tick(1);
      for (int w = 1; w <= 4; w++) begin
         send_word(0, 9'(w), 8, -1, 1, 1'b1, -1);
         q_a.push_back(9'(w));
      end
      tick(2);
      @(negedge clk);
      check("t4_full",     32'(if_a.full),    32'd1);
      check("t4_ovr_pre",  32'(if_a.overrun), 32'd0);
      tick(1);
      send_word(0, 9'h05, 8, -1, 1, 1'b1, -1);
      tick(2);
      @(negedge clk);
      check("t4_overrun",  32'(if_a.overrun), 32'd1);
      check("t4_count",    32'(if_a.count),   32'd4);
      tick(1);
      for (int r = 0; r < 4; r++) read_a();
      @(negedge clk);
      check("t4_empty",    32'(if_a.empty),   32'd1);
      tick(1);
      if_a.err_clr = 1'b1; tick(1); if_a.err_clr = 1'b0;
      @(negedge clk);
      check("t4_ovr_clr",  32'(if_a.overrun), 32'd0);
      tick(1);

      // Short glitch on rx: no frame and no flags.
      rx_a = 1'b0; tick(4); rx_a = 1'b1;
      tick(3 * CPB);
      @(negedge clk);
      check("t5_count", 32'(if_a.count), 32'd0);
      check("t5_flags", 32'({if_a.frame_err, if_a.parity_err, if_a.overrun}), 32'd0);
      tick(1);
      send_word(2, 9'h5A, 7, -1, 2, 1'b1, -1); q_c.push_back(9'h5A);
      tick(2);
      @(negedge clk);
      check("t5_head", 32'(if_c.rd_data), 32'h5A);
      tick(1);
      if_c.rd_en = 1'b1; tick(1); if_c.rd_en = 1'b0;

      // Reset during data bit 3 with a word already stored.
      send_word(0, 9'h11, 8, -1, 1, 1'b1, -1);
      tick(2);
      send_word(0, 9'h3C, 8, -1, 1, 1'b1, 4);
      q_a.delete(); q_b.delete(); q_c.delete();
      @(negedge clk);
      check("t6_empty", 32'(if_a.empty), 32'd1);
      check("t6_count", 32'(if_a.count), 32'd0);
      check("t6_flags", 32'({if_a.frame_err, if_a.parity_err, if_a.overrun}), 32'd0);
      tick(2 * CPB);
      send_word(0, 9'h3C, 8, -1, 1, 1'b1, -1); q_a.push_back(9'h3C);
      tick(2);
      @(negedge clk);
      check("t6_count1", 32'(if_a.count),   32'd1);
      check("t6_head",   32'(if_a.rd_data), 32'h3C);
      tick(1);
      read_a();
      tick(2);

      check("q_a_drained", 32'(q_a.size()), 32'd0);
      check("q_b_drained", 32'(q_b.size()), 32'd0);
      check("q_c_drained", 32'(q_c.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
